// File: rtl/sc_matrixscan.sv
// Row-scan driver for an 8x8 LED matrix: captures the frame at frame start
// and scans one row per slot with a leading blank window. Optional PWM dimming: MATRIXSCAN_DIMMING_EN.
module sc_matrixscan #(
   parameter int MATRIXSCAN_ROWS           = 8,
   parameter int MATRIXSCAN_COLS           = 8,
   parameter int MATRIXSCAN_ROWINDEX_WIDTH = 3,
   parameter int ROW_PERIOD_CYCLES         = 50000,
   parameter int BLANK_CYCLES              = 500
) (
   input  logic                                       SC_MATRIXSCAN_CLOCK_50,
   input  logic                                       SC_MATRIXSCAN_RESET_InHigh,
   input  logic                                       SC_MATRIXSCAN_enable_InHigh,
   input  logic [MATRIXSCAN_ROWS*MATRIXSCAN_COLS-1:0] SC_MATRIXSCAN_frame_InBUS,
`ifdef MATRIXSCAN_DIMMING_EN
   input  logic [3:0]                                 SC_MATRIXSCAN_brightness_InBUS,
`endif
   output logic [MATRIXSCAN_ROWS-1:0]                 SC_MATRIXSCAN_rowselect_OutBUS,
   output logic [MATRIXSCAN_COLS-1:0]                 SC_MATRIXSCAN_col_OutBUS,
   output logic [MATRIXSCAN_ROWINDEX_WIDTH-1:0]       SC_MATRIXSCAN_rowindex_OutBUS,
   output logic                                       SC_MATRIXSCAN_framedone_OutLow
);

   localparam int ROWS  = MATRIXSCAN_ROWS;
   localparam int COLS  = MATRIXSCAN_COLS;
   localparam int RI_W  = MATRIXSCAN_ROWINDEX_WIDTH;
   localparam int CNT_W = (ROW_PERIOD_CYCLES > 1) ? $clog2(ROW_PERIOD_CYCLES) : 1;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ROW_PERIOD_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_BLNK = CNT_W'(BLANK_CYCLES);
   localparam logic [RI_W-1:0]  ROW_LAST = RI_W'(ROWS - 1);
   localparam logic [ROWS-1:0]  ROW_ONE  = {{(ROWS-1){1'b0}}, 1'b1};

   typedef enum logic {ST_IDLE, ST_SCAN} state_t;

   state_t                      state_q, state_d;
   logic [CNT_W-1:0]            cnt_q, cnt_d;
   logic [RI_W-1:0]             row_q, row_d;
   logic [ROWS-1:0][COLS-1:0]   shadow_q, shadow_d;
   logic [ROWS-1:0]             rowsel_q, rowsel_d;
   logic [COLS-1:0]             col_q, col_d;
   logic [RI_W-1:0]             rowidx_q, rowidx_d;
   logic                        fdone_q, fdone_d;
   logic                        show;
`ifdef MATRIXSCAN_DIMMING_EN
   logic [3:0]                  pwm_q, pwm_d, pwm_eff;
`endif

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      row_d    = row_q;
      shadow_d = shadow_q;
      rowsel_d = '1;
      col_d    = '0;
      rowidx_d = '0;
      fdone_d  = 1'b1;
      show     = (cnt_q >= CNT_BLNK);
`ifdef MATRIXSCAN_DIMMING_EN
      pwm_d    = pwm_q;
      pwm_eff  = (cnt_q == CNT_BLNK) ? 4'd0 : pwm_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (SC_MATRIXSCAN_enable_InHigh) begin
               state_d = ST_SCAN;
               cnt_d   = '0;
               row_d   = '0;
            end
         end
         ST_SCAN: begin
            if (!SC_MATRIXSCAN_enable_InHigh) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
               row_d   = '0;
            end else begin
               // Capture lands before the first show cycle since BLANK_CYCLES >= 1.
               if (cnt_q == '0 && row_q == '0)
                  shadow_d = SC_MATRIXSCAN_frame_InBUS;
               rowidx_d = row_q;
               if (show) begin
                  rowsel_d = ~(ROW_ONE << row_q);
                  col_d    = shadow_q[row_q];
`ifdef MATRIXSCAN_DIMMING_EN
                  if (pwm_eff >= SC_MATRIXSCAN_brightness_InBUS)
                     col_d = '0;
                  pwm_d = pwm_eff + 4'd1;
`endif
               end
               if (cnt_q == CNT_LAST) begin
                  cnt_d = '0;
                  if (row_q == ROW_LAST) begin
                     row_d   = '0;
                     fdone_d = 1'b0;
                  end else begin
                     row_d = row_q + 1'b1;
                  end
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge SC_MATRIXSCAN_CLOCK_50 or posedge SC_MATRIXSCAN_RESET_InHigh) begin
      if (SC_MATRIXSCAN_RESET_InHigh) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         row_q    <= '0;
         shadow_q <= '0;
         rowsel_q <= '1;
         col_q    <= '0;
         rowidx_q <= '0;
         fdone_q  <= 1'b1;
`ifdef MATRIXSCAN_DIMMING_EN
         pwm_q    <= '0;
`endif
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         row_q    <= row_d;
         shadow_q <= shadow_d;
         rowsel_q <= rowsel_d;
         col_q    <= col_d;
         rowidx_q <= rowidx_d;
         fdone_q  <= fdone_d;
`ifdef MATRIXSCAN_DIMMING_EN
         pwm_q    <= pwm_d;
`endif
      end
   end

   assign SC_MATRIXSCAN_rowselect_OutBUS = rowsel_q;
   assign SC_MATRIXSCAN_col_OutBUS       = col_q;
   assign SC_MATRIXSCAN_rowindex_OutBUS  = rowidx_q;
   assign SC_MATRIXSCAN_framedone_OutLow = fdone_q;

endmodule

// File: tb/tb_sc_matrixscan.sv
// Scoreboard bench for sc_matrixscan: a frame-position model pushes expected
// outputs at each edge; they are popped and compared on the following falling edge.
module tb_sc_matrixscan;

   localparam int R = 8;
   localparam int C = 8;
   localparam int P = 10;
   localparam int B = 2;
   localparam int FRAME = R * P;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          en  = 1'b0;
   logic [63:0]   frame;
   logic [7:0]    rs, col;
   logic [2:0]    ri;
   logic          fd;
`ifdef MATRIXSCAN_DIMMING_EN
   logic [3:0]    bright = 4'd15;
`endif

   always #5 clk = ~clk;

   sc_matrixscan #(
      .MATRIXSCAN_ROWS(R), .MATRIXSCAN_COLS(C), .MATRIXSCAN_ROWINDEX_WIDTH(3),
      .ROW_PERIOD_CYCLES(P), .BLANK_CYCLES(B)
   ) dut (
      .SC_MATRIXSCAN_CLOCK_50(clk),
      .SC_MATRIXSCAN_RESET_InHigh(rst),
      .SC_MATRIXSCAN_enable_InHigh(en),
      .SC_MATRIXSCAN_frame_InBUS(frame),
`ifdef MATRIXSCAN_DIMMING_EN
      .SC_MATRIXSCAN_brightness_InBUS(bright),
`endif
      .SC_MATRIXSCAN_rowselect_OutBUS(rs),
      .SC_MATRIXSCAN_col_OutBUS(col),
      .SC_MATRIXSCAN_rowindex_OutBUS(ri),
      .SC_MATRIXSCAN_framedone_OutLow(fd)
   );

   typedef struct packed {
      logic [7:0] rs;
      logic [7:0] col;
      logic [2:0] ri;
      logic       fd;
   } exp_t;

   exp_t        q[$];
   int          n_chk = 0;
   int          n_fail = 0;
   int          fd_lows = 0;
   bit          scanning = 1'b0;
   int          k = 0;
   logic [63:0] shadow = '0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
      end
   endtask

   // Model keyed on position k within the scan, not on a slot counter/row register.
   task automatic model_step();
      exp_t e;
      int   r, c;
      e = '{rs: 8'hFF, col: 8'h00, ri: 3'd0, fd: 1'b1};
      if (rst) begin
         scanning = 1'b0;
         k        = 0;
         shadow   = '0;
         return;
      end
      if (!scanning) begin
         if (en) begin
            scanning = 1'b1;
            k        = 0;
         end
      end else if (!en) begin
         scanning = 1'b0;
         k        = 0;
      end else begin
         if (k % FRAME == 0) shadow = frame;
         r    = (k / P) % R;
         c    = k % P;
         e.ri = 3'(r);
         if (c >= B) begin
            e.rs  = ~(8'h01 << r);
            e.col = shadow[r*8 +: 8];
`ifdef MATRIXSCAN_DIMMING_EN
            if ((c - B) >= int'(bright)) e.col = 8'h00;
`endif
         end
         e.fd = !(c == P - 1 && r == R - 1);
         k++;
      end
      q.push_back(e);
   endtask

   initial forever begin
      @(posedge clk);
      model_step();
   end

   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (q.size() > 0) begin
            e = q.pop_front();
            chk("rowselect", rs, e.rs);
            chk("col", col, e.col);
            chk("rowindex", ri, e.ri);
            chk("framedone", fd, e.fd);
         end else if (rst) begin
            chk("rst_rowselect", rs, 8'hFF);
            chk("rst_col", col, 8'h00);
            chk("rst_framedone", fd, 1'b1);
         end
         chk("single_row", ($countones(~rs) <= 1), 1'b1);
         if (!fd) fd_lows++;
      end
   end

   task automatic wait_k(input int tgt);
      int n = 0;
      while (!(scanning && (k % FRAME) == tgt) && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (n >= 300) begin
         n_chk++;
         n_fail++;
         $display("FAIL wait_k timeout: position %0d not reached", tgt);
      end
   endtask

   initial begin
      int snap;
      for (int r = 0; r < R; r++) frame[r*8 +: 8] = 8'h01 << r;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (20) @(negedge clk);

      // Two full frames; row 3 rewritten while row 1 is in its slot.
      fd_lows = 0;
      en = 1'b1;
      repeat (15) @(negedge clk);
      frame[24 +: 8] = 8'hAA;
      repeat (160) @(negedge clk);
      chk("framedone_pulses", fd_lows, 2);

      // Drop enable in row 5's show window; no framedone afterwards.
      wait_k(55);
      en   = 1'b0;
      snap = fd_lows;
      repeat (6) @(negedge clk);
      chk("no_fd_after_disable", fd_lows, snap);
      frame[40 +: 8] = 8'h5C;
      en = 1'b1;
      repeat (90) @(negedge clk);

      // Asynchronous reset in row 3's show window.
      wait_k(34);
      @(posedge clk);
      #1 chk("pre_reset_rowselect", rs, 8'hF7);
      #1 rst = 1'b1;
      #1 chk("async_rowselect", rs, 8'hFF);
      chk("async_col", col, 8'h00);
      q.delete();
      en = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      en = 1'b1;
      repeat (90) @(negedge clk);

`ifdef MATRIXSCAN_DIMMING_EN
      en = 1'b0;
      frame = '1;
      bright = 4'd4;
      @(negedge clk);
      en = 1'b1;
      repeat (90) @(negedge clk);
      bright = 4'd0;
      repeat (90) @(negedge clk);
`endif

      en = 1'b0;
      repeat (4) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/sc_matrixscan.md
Name: sc_matrixscan

Overview:
- Reader end of the row-register bank: samples all 8 background/object row registers and scans them onto the 8x8 LED matrix one row at a time.
- Double-buffers the frame at frame start so writers (load/shift/transition) never tear a displayed frame.
- Sits between the row-register bank and the top-level matrix pins.
- Emits a frame-done strobe that game-timing logic can use.

Parameters:
- MATRIXSCAN_ROWS, 8, number of rows scanned.
- MATRIXSCAN_COLS, 8, row data width; equals the row-register data width.
- MATRIXSCAN_ROWINDEX_WIDTH, 3, width of the row index; 2^width >= ROWS.
- ROW_PERIOD_CYCLES, 50000, clock cycles per row slot (1 ms at 50 MHz).
- BLANK_CYCLES, 500, anti-ghosting blank cycles at the start of each slot; 1 <= BLANK_CYCLES < ROW_PERIOD_CYCLES.

Ports:
- SC_MATRIXSCAN_CLOCK_50  in  1  system clock.
- SC_MATRIXSCAN_RESET_InHigh  in  1  reset.
- SC_MATRIXSCAN_enable_InHigh  in  1  scan enable.
- SC_MATRIXSCAN_frame_InBUS  in  ROWS*COLS  row r on bits [r*COLS +: COLS]; row 0 is the top row.
- SC_MATRIXSCAN_rowselect_OutBUS  out  ROWS  one-hot active-low row drive.
- SC_MATRIXSCAN_col_OutBUS  out  COLS  column data, 1 = LED lit.
- SC_MATRIXSCAN_rowindex_OutBUS  out  ROWINDEX_WIDTH  row currently in its slot.
- SC_MATRIXSCAN_framedone_OutLow  out  1  one-cycle low pulse at end of frame.

Interface: one clock; reset is asynchronous and active-high.

Behaviour:
- All outputs are registered.
- Reset values:
  - rowselect = all 1s, col = 0, rowindex = 0, framedone = 1.
  - Shadow buffer = 0, slot counter cnt = 0, state = IDLE.
- States:
  - IDLE: outputs at reset values. When enable = 1 is sampled, next state is SCAN with cnt = 0 and row = 0.
  - SCAN: cnt counts 0..ROW_PERIOD_CYCLES-1 and wraps to 0.
- Shadow capture: at every cnt = 0 with row = 0 (including the first SCAN cycle), shadow <= frame_InBUS. Writer changes during the frame are invisible until the next capture.
- Blank window (cnt < BLANK_CYCLES): rowselect = all 1s, col = 0.
- Show window (cnt >= BLANK_CYCLES):
  - rowselect = ~(1 << row).
  - col = shadow row[row].
  - Outputs reflect state one cycle later because they are registered.
- Row advance at cnt = ROW_PERIOD_CYCLES-1:
  - If row < ROWS-1, then row <= row+1.
  - Otherwise row <= 0 and framedone pulses low for exactly that cycle (registered, so visible on the following cycle).
- Frame length is exactly ROWS*ROW_PERIOD_CYCLES cycles, with no extra load cycle.
- rowindex tracks row during SCAN, including blank windows.
- enable = 0 sampled in any SCAN cycle:
  - Next state is IDLE; outputs are off on the next edge.
  - cnt and row are cleared; no framedone is emitted.
  - Re-enable restarts at row 0 with a fresh capture.
- Reset asserted mid-frame: outputs return to reset values immediately (asynchronous reset). The shadow is cleared.
- Only one row is ever driven low; no two rows overlap, including at row transitions, because the blank window separates them.

Optional Feature:
- Macro: MATRIXSCAN_DIMMING_EN.
- Defined:
  - Adds input SC_MATRIXSCAN_brightness_InBUS, 4 bits.
  - Adds a 4-bit PWM counter pwm, cleared at cnt = BLANK_CYCLES and incremented every show cycle.
  - In the show window, col = shadow row when pwm < brightness, else col = 0; rowselect is unchanged.
  - brightness = 0 gives a dark matrix; brightness = 15 gives 15/16 duty.
  - brightness is sampled each cycle.
- Undefined: no port and no PWM; col is full-on through the show window.

Test Plan (ROW_PERIOD_CYCLES=10, BLANK_CYCLES=2, ROWS=COLS=8):
- Reset with enable = 0 for 20 cycles -> rowselect = 8'hFF, col = 8'h00, framedone = 1 throughout.
- Frame with row r = 8'h01<<r, enable = 1:
  - Each row slot: 2 cycles blank, then 8 cycles with rowselect = ~(1<<r) and col = 8'h01<<r.
  - Rows advance 0..7; framedone is low for exactly 1 cycle every 80 cycles.
- Change frame_InBUS row 3 to 8'hAA during row 1's slot -> row 3 still shows the old value this frame; 8'hAA appears next frame.
- Drop enable during row 5's show window -> outputs off one cycle later; no framedone. Re-enable -> scan restarts at row 0 with a fresh capture.
- Assert reset mid-show -> rowselect = 8'hFF and col = 0 asynchronously (before the next edge). After release and re-enable, scanning restarts at row 0.
- With MATRIXSCAN_DIMMING_EN and brightness = 4, all rows 8'hFF -> col = 8'hFF for the first 4 of 8 show cycles, then 0. With brightness = 0, col stays 0 for the whole frame.
